// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode holding {pc, inst} pairs; flushed on redirect.
// Optional empty-queue bypass path enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic head_valid;
    logic push_wr;
    logic pop_mem;

    assign head_valid = (count_q != '0);
    assign in_ready   = (count_q != FULL);
    assign count      = count_q;
    assign pop_mem    = head_valid & out_ready;

`ifdef FETCHQ_BYPASS_EN
    logic byp;

    // An empty queue forwards the incoming pair; it is only stored if decode stalls.
    assign byp       = ~head_valid & in_valid & ~flush & ~rst;
    assign out_valid = head_valid | byp;
    assign push_wr   = in_valid & in_ready & ~(byp & out_ready);

    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (head_valid) begin
            out_pc   = pc_mem_q[rd_ptr_q];
            out_inst = inst_mem_q[rd_ptr_q];
        end else if (byp) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end
    end
`else
    assign out_valid = head_valid;
    assign push_wr   = in_valid & in_ready;

    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (head_valid) begin
            out_pc   = pc_mem_q[rd_ptr_q];
            out_inst = inst_mem_q[rd_ptr_q];
        end
    end
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_wr) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_mem) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push_wr, pop_mem})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_wr && !flush) begin
            pc_mem_q[wr_ptr_q]   <= in_pc;
            inst_mem_q[wr_ptr_q] <= in_inst;
        end
    end

endmodule
